// File: rtl/arithm_sched.sv
// arithm_sched: round-robin scheduler feeding one shared LAT-stage arithm unit, with id tracking and stall control.
// Optional per-requester grant counters (stat_grants) when ARITHM_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module arithm_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 5,
  parameter int W    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ*W-1:0]   req_c,
  output logic                arith_ce,
  output logic [W-1:0]        arith_a,
  output logic [W-1:0]        arith_b,
  output logic [W-1:0]        arith_c,
  input  logic [W-1:0]        arith_o,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2:0]          res_id,
  output logic [W-1:0]        res_data,
  output logic                busy
`ifdef ARITHM_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]  stat_grants
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [2:0]     idpipe_q [LAT];
  logic [2:0]     idpipe_d [LAT];
  logic [PW-1:0]  ptr_q, ptr_d;

  logic            gnt_found;
  logic [2:0]      gnt_id;
  logic [NREQ-1:0] grant;
  int              idx;
  int              nxt;

  // A result waiting at the tail with no taker freezes every stage.
  assign arith_ce = !(vpipe_q[LAT-1] && !res_ready);

  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_id    = 3'd0;
    arith_a   = '0;
    arith_b   = '0;
    arith_c   = '0;
    idx       = 0;
    if (arith_ce && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_found && req_valid[idx]) begin
          gnt_found  = 1'b1;
          grant[idx] = 1'b1;
          gnt_id     = 3'(idx);
          arith_a    = req_a[idx*W +: W];
          arith_b    = req_b[idx*W +: W];
          arith_c    = req_c[idx*W +: W];
        end
      end
    end
  end

  always_comb begin
    nxt = int'(gnt_id) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_d = gnt_found ? PW'(nxt) : ptr_q;
  end

  always_comb begin
    vpipe_d = vpipe_q;
    for (int i = 0; i < LAT; i++) idpipe_d[i] = idpipe_q[i];
    if (arith_ce) begin
      vpipe_d     = {vpipe_q[LAT-2:0], gnt_found};
      idpipe_d[0] = gnt_id;
      for (int i = 1; i < LAT; i++) idpipe_d[i] = idpipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < LAT; i++) idpipe_q[i] <= 3'd0;
    end else begin
      vpipe_q <= vpipe_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < LAT; i++) idpipe_q[i] <= idpipe_d[i];
    end
  end

  // Outputs are masked during reset so the flush is visible in the reset cycle itself.
  assign req_ready = grant;
  assign res_valid = vpipe_q[LAT-1] && !rst;
  assign res_id    = rst ? 3'd0 : idpipe_q[LAT-1];
  assign res_data  = arith_o;
  assign busy      = (|vpipe_q) && !rst;

`ifdef ARITHM_SCHED_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stat_pack
      assign stat_grants[gi*16 +: 16] = cnt_q[gi];
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_arithm_sched.sv
// tb_arithm_sched: directed self-checking bench for arithm_sched with a behavioural pipelined arithm unit.
`timescale 1ns/1ps
`default_nettype none

module tb_arithm_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 5;
  localparam int W    = 14;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b, req_c;
  logic              arith_ce;
  logic [W-1:0]      arith_a, arith_b, arith_c, arith_o;
  logic              res_valid;
  logic              res_ready;
  logic [2:0]        res_id;
  logic [W-1:0]      res_data;
  logic              busy;
`ifdef ARITHM_SCHED_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
`endif

  arithm_sched #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .arith_ce(arith_ce), .arith_a(arith_a), .arith_b(arith_b), .arith_c(arith_c),
    .arith_o(arith_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .busy(busy)
`ifdef ARITHM_SCHED_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // O = ((A+B)*C)[27:14] on signed operands
  function automatic logic [W-1:0] ref_o(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    longint s, p;
    logic [63:0] pv;
    s  = longint'($signed(a)) + longint'($signed(b));
    p  = s * longint'($signed(c));
    pv = p;
    return pv[27:14];
  endfunction

  logic [W-1:0] mp [LAT];
  always @(posedge clk) begin
    if (arith_ce) begin
      mp[0] <= ref_o(arith_a, arith_b, arith_c);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign arith_o = mp[LAT-1];

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           last_gnt, last_res_id, g_cyc, r_cyc, first_r_cyc;
  logic [W-1:0] last_res_data;
  int           n_push = 0;
  int           n_pop = 0;
  int           qid[$];
  logic [W-1:0] qdat[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample transfers at negedge+1, advance to the next negedge.
  task automatic step();
    logic was_rst;
    #1;
    last_gnt = -1;
    check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        last_gnt = i;
        g_cyc    = cyc;
        qid.push_back(i);
        qdat.push_back(ref_o(req_a[i*W +: W], req_b[i*W +: W], req_c[i*W +: W]));
        n_push++;
      end
    end
    if (res_valid && res_ready) begin
      if (qid.size() == 0) begin
        check("sb_spurious", 32'd1, 32'd0);
      end else begin
        check("sb_id", 32'(res_id), 32'(qid.pop_front()));
        check("sb_data", 32'(res_data), 32'(qdat.pop_front()));
      end
      if (n_pop == 0) first_r_cyc = cyc;
      n_pop++;
      r_cyc         = cyc;
      last_res_id   = int'(res_id);
      last_res_data = res_data;
    end
    was_rst = rst;
    @(posedge clk);
    if (was_rst) begin
      qid.delete();
      qdat.delete();
      n_push = 0;
      n_pop  = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    req_valid = '0;
    res_ready = 1'b1;
    while (n_pop < n_push && g < 40) begin
      step();
      g++;
    end
    check(tag, 32'(n_pop), 32'(n_push));
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [W-1:0] hold;
    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, 14'(5 + i), 14'(6 + i), 14'(7 + i));
    @(negedge clk);
    step();
    step();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ce", 32'(arith_ce), 32'd1);
    check("rst_arith_a", 32'(arith_a), 32'd0);
    check("rst_arith_b", 32'(arith_b), 32'd0);
    check("rst_arith_c", 32'(arith_c), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst       = 1'b0;
    req_valid = '0;

    // single op: (100+28)*2048 = 2^18 -> bits [27:14] = 16
    set_op(0, 14'd100, 14'd28, 14'd2048);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    check("t1_arith_a", 32'(arith_a), 32'd100);
    step();
    req_valid = '0;
    g = 0;
    while (n_pop < 1 && g < 20) begin step(); g++; end
    check("t1_done", 32'(n_pop), 32'd1);
    check("t1_latency", 32'(r_cyc - g_cyc), 32'(LAT));
    check("t1_id", 32'(last_res_id), 32'd0);
    check("t1_data", 32'(last_res_data), 32'd16);
    #1;
    check("t1_idle", 32'(busy), 32'd0);

    // all four continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 14'(10 * i + 1), 14'(3 * i + 2), 14'(4096 + 1000 * i));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("t2_grant", 32'(last_gnt), 32'(k % 4));
    end
    drain("t2_drain");
    check("t2_count", 32'(n_pop), 32'd12);
    check("t2_no_bubble", 32'(r_cyc - first_r_cyc), 32'd11);

    // stall under back-pressure
    do_reset();
    req_valid = 4'b0111;
    res_ready = 1'b0;
    repeat (3) step();
    req_valid = '0;
    g = 0;
    while (!res_valid && g < 20) begin step(); g++; end
    check("t3_head", 32'(res_valid), 32'd1);
    req_valid = 4'b1000;
    hold = res_data;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_ce", 32'(arith_ce), 32'd0);
      check("t3_ready", 32'(req_ready), 32'd0);
      check("t3_data_hold", 32'(res_data), 32'(hold));
      check("t3_id", 32'(res_id), 32'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    drain("t3_drain");
    check("t3_count", 32'(n_pop), 32'd4);

    // fairness from ptr=2
    do_reset();
    req_valid = 4'b0010;
    step();
    check("t4_first", 32'(last_gnt), 32'd1);
    req_valid = 4'b1010;
    step();
    check("t4_g1", 32'(last_gnt), 32'd3);
    step();
    check("t4_g2", 32'(last_gnt), 32'd1);
    step();
    check("t4_g3", 32'(last_gnt), 32'd3);
    drain("t4_drain");

    // reset with 4 ops in flight and the head at the output
    do_reset();
    req_valid = 4'b1111;
    repeat (4) step();
    req_valid = '0;
    step();
    #1;
    check("t5_head_pre", 32'(res_valid), 32'd1);
    rst       = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("t5_post_valid", 32'(res_valid), 32'd0);
    check("t5_post_busy", 32'(busy), 32'd0);
    check("t5_post_ce", 32'(arith_ce), 32'd1);
    check("t5_post_grant", 32'(req_ready), 32'b0010);
    step();
    drain("t5_drain");
    check("t5_count", 32'(n_pop), 32'd1);

`ifdef ARITHM_SCHED_STATS_EN
    do_reset();
    req_valid = 4'b0001;
    repeat (3) step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0100;
    repeat (70000) step();
    drain("t6_drain");
    check("t6_cnt0", 32'(stat_grants[0 +: 16]), 32'd3);
    check("t6_cnt1", 32'(stat_grants[16 +: 16]), 32'd1);
    check("t6_cnt2", 32'(stat_grants[32 +: 16]), 32'hFFFF);
    check("t6_cnt3", 32'(stat_grants[48 +: 16]), 32'd0);
    do_reset();
    #1;
    check("t6_cleared", 32'(stat_grants != '0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
